// File: rtl/bnn_pkg.sv
// Shared definitions for the binary neural network layer engine:
// controller state encoding and default datapath sizing.
package bnn_pkg;

    localparam int DEF_LANES = 8;
    localparam int DEF_ACC_W = 13;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        ACC       = 3'd2,
        STORE_SET = 3'd3,
        STORE_WR  = 3'd4,
        NEXT      = 3'd5,
        DONE      = 3'd6
    } state_t;

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount: the number of lanes where weight and
// activation bits agree.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    localparam int CW   = $clog2(LANES + 1)
) (
    input  logic [LANES-1:0] w,
    input  logic [LANES-1:0] x,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            count = count + CW'(~(w[i] ^ x[i]));
        end
    end

endmodule

// File: rtl/bnn_layer_engine.sv
// Sequential binary fully-connected layer: XNOR-popcount accumulate per
// neuron, sign-bit write-back. Optional argmax tracker under BNN_ARGMAX_EN.
module bnn_layer_engine
    import bnn_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int W_ADDR_LEN = 20,
    parameter int X_ADDR_LEN = 10,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int SEL_LEN    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [X_ADDR_LEN-1:0] in_words,
    input  logic [X_ADDR_LEN-1:0] out_len,
    input  logic [SEL_LEN-1:0]    src_sel,
    input  logic [SEL_LEN-1:0]    dst_sel,
    input  logic [SEL_LEN-1:0]    w_sel_in,
    output logic                  busy,
    output logic                  done,
    output logic [SEL_LEN-1:0]    w_sel,
    output logic [W_ADDR_LEN-1:0] w_addr,
    input  logic [LANES-1:0]      w_data,
    output logic [SEL_LEN-1:0]    x_sel,
    output logic [X_ADDR_LEN-1:0] x_addr,
    input  logic [LANES-1:0]      x_data,
    output logic                  x_wq,
    output logic                  x_wdata,
    output logic [X_ADDR_LEN-1:0] class_idx,
    output logic                  class_vld
);

    localparam int CW = $clog2(LANES + 1);

    state_t state, state_d;

    logic [X_ADDR_LEN-1:0]   in_words_q, out_len_q, neuron, word;
    logic [SEL_LEN-1:0]      src_q, dst_q, wsel_q;
    logic [W_ADDR_LEN-1:0]   w_ptr;
    logic signed [ACC_W-1:0] acc, delta;
    logic [CW-1:0]           pc;
    logic                    last_word, last_neuron, storing, done_q;

    bnn_xnor_popcount #(.LANES(LANES)) u_pop (
        .w     (w_data),
        .x     (x_data),
        .count (pc)
    );

    // Agreements count +1, disagreements -1: 2*pc - LANES.
    assign delta       = ACC_W'(2 * int'(pc)) - ACC_W'(LANES);
    assign last_word   = (word == in_words_q - 1'b1);
    assign last_neuron = (neuron == out_len_q - 1'b1);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:      if (start) state_d = (in_words == '0 || out_len == '0) ? DONE : FETCH;
            FETCH:     state_d = ACC;
            ACC:       state_d = last_word ? STORE_SET : FETCH;
            STORE_SET: state_d = STORE_WR;
            STORE_WR:  state_d = NEXT;
            NEXT:      state_d = last_neuron ? DONE : FETCH;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_words_q <= '0;
            out_len_q  <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            wsel_q     <= '0;
            neuron     <= '0;
            word       <= '0;
            w_ptr      <= '0;
            acc        <= '0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_d;
            done_q <= (state == DONE);
            unique case (state)
                IDLE: if (start) begin
                    in_words_q <= in_words;
                    out_len_q  <= out_len;
                    src_q      <= src_sel;
                    dst_q      <= dst_sel;
                    wsel_q     <= w_sel_in;
                    neuron     <= '0;
                    word       <= '0;
                    w_ptr      <= '0;
                    acc        <= '0;
                end
                ACC: begin
                    acc   <= acc + delta;
                    // Pointer simply keeps counting across neurons: n*in_words+k.
                    w_ptr <= w_ptr + 1'b1;
                    if (!last_word) word <= word + 1'b1;
                end
                NEXT: begin
                    acc  <= '0;
                    word <= '0;
                    if (!last_neuron) neuron <= neuron + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign storing = (state == STORE_SET) || (state == STORE_WR);
    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = done_q;
    assign w_sel   = wsel_q;
    assign w_addr  = w_ptr;
    assign x_sel   = storing ? dst_q : src_q;
    assign x_addr  = storing ? neuron : word;
    assign x_wq    = (state == STORE_WR);
    assign x_wdata = storing & ~acc[ACC_W-1];

`ifdef BNN_ARGMAX_EN
    logic signed [ACC_W-1:0] best_acc;
    logic [X_ADDR_LEN-1:0]   best_idx, class_idx_q;
    logic                    class_vld_q;

    // Strict greater-than keeps the lowest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_acc    <= '0;
            best_idx    <= '0;
            class_idx_q <= '0;
            class_vld_q <= 1'b0;
        end else if (state == IDLE && start) begin
            best_acc    <= '0;
            best_idx    <= '0;
            class_idx_q <= '0;
            class_vld_q <= 1'b0;
        end else if (state == NEXT && (neuron == '0 || acc > best_acc)) begin
            best_acc <= acc;
            best_idx <= neuron;
        end else if (state == DONE) begin
            class_idx_q <= best_idx;
            class_vld_q <= 1'b1;
        end
    end

    assign class_idx = class_idx_q;
    assign class_vld = class_vld_q;
`else
    assign class_idx = '0;
    assign class_vld = 1'b0;
`endif

endmodule

// File: doc/bnn_layer_engine.md
BNN_LAYER_ENGINE -- requirements
Module: bnn_layer_engine

Interface
REQ-001 Parameter LANES, default 8: input bits consumed per accumulate step (XNOR lanes).
REQ-002 Parameter W_ADDR_LEN, default 20: weight word-address width.
REQ-003 Parameter X_ADDR_LEN, default 10: activation address width, used for both read and write.
REQ-004 Parameter ACC_W, default 13: signed accumulator width.
REQ-005 Parameter SEL_LEN, default 2: memory bank-select width.
REQ-006 Port clk, input, 1: the only clock; all logic samples on its rising edge.
REQ-007 Port rst, input, 1: reset, synchronous and active-high.
REQ-008 Port start, input, 1: one-cycle request to run one layer.
REQ-009 Port in_words, input, X_ADDR_LEN: LANES-bit input words per neuron.
REQ-010 Port out_len, input, X_ADDR_LEN: number of output neurons.
REQ-011 Port src_sel / dst_sel, input, SEL_LEN each: source and destination activation bank.
REQ-012 Port w_sel_in, input, SEL_LEN: weight bank.
REQ-013 Port busy / done, output, 1 each: busy while running; done is a one-cycle completion pulse.
REQ-014 Port w_sel, w_addr, output, SEL_LEN / W_ADDR_LEN: weight read select and address.
REQ-015 Port w_data, input, LANES: weight word, valid one cycle after w_addr.
REQ-016 Port x_sel, x_addr, output, SEL_LEN / X_ADDR_LEN: activation select and address (shared read/write).
REQ-017 Port x_data, input, LANES: activation word, valid one cycle after x_addr.
REQ-018 Port x_wq, x_wdata, output, 1 / 1: single-bit activation write strobe and data.
REQ-019 Port class_idx, class_vld, output, X_ADDR_LEN / 1: argmax result (see REQ-033).

Function
REQ-020 States SHALL be IDLE, FETCH, ACC, STORE_SET, STORE_WR, NEXT, DONE.
REQ-021 IDLE + start: latch in_words, out_len and sels; clear neuron, word, acc and w_addr; go to FETCH; busy=1 from the next cycle.
REQ-022 start with in_words==0 or out_len==0: go directly to DONE, with no memory writes.
REQ-023 FETCH: drive w_addr=w_ptr, x_sel=src_sel, x_addr=word; next state ACC.
REQ-024 ACC: acc += 2*popcount(~(w_data^x_data)) - LANES, in ACC_W-bit two's complement, wrapping; w_ptr++.
REQ-024a ACC: if word==in_words-1, go to STORE_SET; else word++ and go to FETCH.
REQ-025 STORE_SET: x_sel=dst_sel, x_addr=neuron, x_wdata=~acc[ACC_W-1] (acc>=0 writes 1); x_wq=0.
REQ-026 STORE_WR: x_wq=1 for exactly one cycle, with address and data held stable from STORE_SET.
REQ-027 NEXT: x_wq=0; acc=0; word=0.
REQ-027a NEXT: if neuron==out_len-1, go to DONE; else neuron++ and go to FETCH.
REQ-028 w_ptr runs contiguously across neurons: neuron n word k is at n*in_words+k, with no multiplier.
REQ-029 DONE: done=1 for one cycle, busy=0, return to IDLE.
REQ-030 start while busy SHALL be ignored.
REQ-031 A cycle count per layer is fixed: out_len*(2*in_words+3)+2 from start to done.

Reset
REQ-032 With rst=1 at a clock edge, the block SHALL go to IDLE from any state, including mid-layer.
REQ-032a Reset values: busy, done, x_wq, x_wdata, class_vld = 0; w_addr, x_addr, w_sel, x_sel, class_idx = 0; acc = 0; no write strobe on the next cycle.

Configuration
REQ-033 Macro BNN_ARGMAX_EN defined: track the maximum acc across neurons at NEXT; the lowest index wins ties.
REQ-033a With BNN_ARGMAX_EN: class_idx is the winning neuron, class_vld=1 together with done and held until the next start or rst.
REQ-034 Macro BNN_ARGMAX_EN undefined: no comparator logic; class_idx=0 and class_vld=0 at all times.

Structure
REQ-035 Shared package bnn_pkg: state encoding constants and the default LANES/ACC_W values.
REQ-036 One sub-module, bnn_xnor_popcount: combinational popcount of the XNOR, LANES inputs, $clog2(LANES+1)-bit output.

Verification
REQ-037 LANES=8, in_words=1, out_len=1, w=0xFF, x=0xFF -> acc=+8, x_wdata=1, one x_wq pulse, done at cycle 7.
REQ-038 w=0x00, x=0xFF, in_words=2 -> acc=-16, x_wdata=0 written at x_addr=0 on dst_sel.
REQ-039 Mixed data giving acc==0 -> x_wdata=1; w_addr sequence 0..(out_len*in_words-1) contiguous with no gaps.
REQ-040 rst asserted in STORE_SET on neuron 2 -> no x_wq that layer; IDLE next cycle; outputs at reset values; a fresh start runs correctly.
REQ-041 in_words=0 -> done 2 cycles after start, zero writes; start pulsed while busy -> no effect on counters.
REQ-042 BNN_ARGMAX_EN, out_len=4, accs {3,7,7,-2} -> class_idx=1, class_vld=1 with done; without macro -> class_vld stays 0.
